// File: rtl/clk_mon_pkg.sv
// -----------------------------------------------------------------------------
// clk_mon_pkg
// Shared definitions for the divided-clock monitor:
//   - mon_state_t : monitor FSM state encoding
//   - DEF_*       : default parameter values used by clk_monitor
// -----------------------------------------------------------------------------
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // monitor disabled, counters parked
        ST_ARM     = 2'd1,  // enabled, waiting for the first rising edge
        ST_MEASURE = 2'd2,  // first edge seen, counting towards the second
        ST_LOCKED  = 2'd3   // period measurement valid, refreshed every edge
    } mon_state_t;

    localparam int DEF_PERIOD_WIDTH = 16;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_STALL_CYCLES = 65535;

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings a single asynchronous level into the clk_i domain through a STAGES-deep
// flop chain and produces registered one-cycle rise/fall pulses.
//
// Parameters:
//   STAGES   synchronizer depth (2..4)
// Ports:
//   clk_i    input   destination-domain clock
//   rst_i    input   asynchronous, active-high reset
//   async_i  input   level from a foreign clock domain
//   level_o  output  synchronized level, aligned with the tick outputs: it goes
//                    high in the rise_o cycle and low in the fall_o cycle
//   rise_o   output  one-cycle pulse per rising edge of async_i
//   fall_o   output  one-cycle pulse per falling edge of async_i
// -----------------------------------------------------------------------------
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync_q [STAGES];
    logic s_last;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    // First stage samples the asynchronous input directly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q[0] <= 1'b0;
        end else begin
            sync_q[0] <= async_i;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_sync
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sync_q[gi] <= 1'b0;
                end else begin
                    sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign s_last = sync_q[STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= s_last;
            rise_q <= s_last & ~prev_q;
            fall_q <= ~s_last & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/clk_monitor.sv
// -----------------------------------------------------------------------------
// clk_monitor
// Watches the slow divided clock from the programmable clock-source divider.
// The divided clock is only ever sampled as data: it is synchronized into iCLK
// and turned into rise/fall enable ticks, its rise-to-rise period is measured in
// iCLK cycles, and a stall is flagged when rising edges stop arriving.
//
// Build option:
//   CLK_MON_DUTY_EN  when defined, high_time reports the high-phase length of
//                    slow_clk in iCLK cycles; otherwise high_time is tied to 0.
//
// Parameters:
//   SYNC_STAGES   synchronizer depth (2..4)
//   PERIOD_WIDTH  width of the interval counters and measurement outputs
//   STALL_CYCLES  cycles without a rising edge before a stall (2..2^PERIOD_WIDTH-1)
// Ports:
//   iCLK          input   fast system clock
//   iRST          input   asynchronous, active-high reset
//   iEN           input   monitor enable (synchronous)
//   slow_clk      input   divided clock, asynchronous to iCLK
//   rise_tick     output  one-cycle pulse per slow_clk rising edge
//   fall_tick     output  one-cycle pulse per slow_clk falling edge
//   period        output  last rise-to-rise interval in iCLK cycles
//   period_valid  output  period holds a valid measurement
//   stalled       output  no rising edge for STALL_CYCLES cycles
//   high_time     output  high-phase length (0 unless CLK_MON_DUTY_EN)
// -----------------------------------------------------------------------------
module clk_monitor
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iEN,
    input  logic                    slow_clk,
    output logic                    rise_tick,
    output logic                    fall_tick,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    stalled,
    output logic [PERIOD_WIDTH-1:0] high_time
);

    localparam logic [PERIOD_WIDTH-1:0] CNT_ONE   = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] STALL_VAL = PERIOD_WIDTH'(STALL_CYCLES);

    logic sync_level;
    logic sync_rise;
    logic sync_fall;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk_i   (iCLK),
        .rst_i   (iRST),
        .async_i (slow_clk),
        .level_o (sync_level),
        .rise_o  (sync_rise),
        .fall_o  (sync_fall)
    );

    assign rise_tick = sync_rise;
    assign fall_tick = sync_fall;

    // -------------------------------------------------------------------------
    // Period measurement FSM
    // -------------------------------------------------------------------------
    mon_state_t              state_q,   state_d;
    logic [PERIOD_WIDTH-1:0] cnt_q,     cnt_d;
    logic [PERIOD_WIDTH-1:0] period_q,  period_d;
    logic                    valid_q,   valid_d;
    logic                    stalled_q, stalled_d;

    logic [PERIOD_WIDTH-1:0] cnt_run;
    logic                    stall_hit;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = valid_q;
        stalled_d = stalled_q;

        // Restarting at 1 on the tick makes cnt equal the distance in cycles
        // back to the previous tick when the next one arrives. The counter
        // saturates so a STALL_CYCLES of all-ones is still reached.
        if (sync_rise) begin
            cnt_run = CNT_ONE;
        end else if (&cnt_q) begin
            cnt_run = cnt_q;
        end else begin
            cnt_run = cnt_q + CNT_ONE;
        end

        stall_hit = (cnt_q == STALL_VAL);

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                valid_d   = 1'b0;
                stalled_d = 1'b0;
                if (iEN) begin
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                cnt_d   = cnt_run;
                valid_d = 1'b0;
                if (!iEN) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    stalled_d = 1'b0;
                end else if (sync_rise) begin
                    // A stall raised earlier is cleared by the first new edge.
                    state_d   = ST_MEASURE;
                    stalled_d = 1'b0;
                end
            end

            ST_MEASURE, ST_LOCKED: begin
                cnt_d = cnt_run;
                // Priority: disable beats a tick, a tick beats a stall.
                if (!iEN) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    valid_d   = 1'b0;
                    stalled_d = 1'b0;
                end else if (sync_rise) begin
                    state_d   = ST_LOCKED;
                    period_d  = cnt_q;
                    valid_d   = 1'b1;
                    stalled_d = 1'b0;
                end else if (stall_hit) begin
                    state_d   = ST_ARM;
                    valid_d   = 1'b0;
                    stalled_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign stalled      = stalled_q;

    // -------------------------------------------------------------------------
    // High-phase measurement
    // -------------------------------------------------------------------------
`ifdef CLK_MON_DUTY_EN
    logic [PERIOD_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [PERIOD_WIDTH-1:0] high_q, high_d;

    // sync_level is high from the rise-tick cycle up to (not including) the
    // fall-tick cycle, so counting on it makes high_time equal the distance
    // between the two ticks, just as period is the distance between rises.
    always_comb begin
        hcnt_d = hcnt_q;
        high_d = high_q;
        if (sync_rise) begin
            hcnt_d = CNT_ONE;
        end else if (sync_level && !(&hcnt_q)) begin
            hcnt_d = hcnt_q + CNT_ONE;
        end
        if (sync_fall) begin
            high_d = hcnt_q;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign high_time = high_q;
`else
    logic unused_sync_level;
    assign unused_sync_level = sync_level;
    assign high_time         = '0;
`endif

endmodule
